// File: rtl/myproject_mac_accum.sv
// Streaming MAC accumulator: sums NUM_TAPS products plus a bias, rounds, shifts and saturates.
// Optional macro MYPROJECT_MAC_ACCUM_RELU_EN clamps negative results to zero (ReLU activation).
module myproject_mac_accum #(
    parameter int unsigned PROD_WIDTH = 30,
    parameter int unsigned NUM_TAPS   = 9,
    parameter int unsigned ACC_WIDTH  = 38,
    parameter int unsigned BIAS_WIDTH = 16,
    parameter int unsigned FRAC_SHIFT = 10,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic [BIAS_WIDTH-1:0] in_bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag
);

    localparam int unsigned TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
    localparam int unsigned RND_W = ACC_WIDTH + 1;
    localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX =
        {{(RND_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    if (NUM_TAPS < 1 || NUM_TAPS > 256) begin : g_bad_taps
        $error("NUM_TAPS must be in 1..256");
    end
    if (ACC_WIDTH < PROD_WIDTH + $clog2(NUM_TAPS) + 1 || ACC_WIDTH <= BIAS_WIDTH) begin : g_bad_acc
        $error("ACC_WIDTH too narrow for products and bias");
    end
    if (FRAC_SHIFT < 1 || OUT_WIDTH >= RND_W) begin : g_bad_fmt
        $error("FRAC_SHIFT must be >= 1 and OUT_WIDTH below ACC_WIDTH + 1");
    end

    typedef enum logic {StAccum, StFull} state_e;

    state_e                       state_q, state_d;
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [OUT_WIDTH-1:0]         data_q, data_d;
    logic                         sat_q, sat_d;

    logic                         accept, deliver, last_tap;
    logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext, base, sum;
    logic signed [RND_W-1:0]      rnd, shr;
    logic                         clip_hi, clip_lo;
    logic [OUT_WIDTH-1:0]         res;

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign last_tap  = accept && (tap_q == LAST_TAP);

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
    assign bias_ext = {{(ACC_WIDTH - BIAS_WIDTH){in_bias[BIAS_WIDTH-1]}}, in_bias};

    // Tap 0 seeds from the bias; this also covers the single-tap configuration.
    assign base = (tap_q == '0) ? bias_ext : acc_q;
    assign sum  = base + prod_ext;

    // One extra bit keeps the rounding offset from wrapping at the top of the range.
    assign rnd     = {sum[ACC_WIDTH-1], sum} + HALF;
    assign shr     = rnd >>> FRAC_SHIFT;
    assign clip_hi = (shr > SAT_MAX);
    assign clip_lo = (shr < SAT_MIN);

    always_comb begin
        res = shr[OUT_WIDTH-1:0];
        if (clip_hi) begin
            res = SAT_MAX[OUT_WIDTH-1:0];
        end else if (clip_lo) begin
            res = SAT_MIN[OUT_WIDTH-1:0];
        end
`ifdef MYPROJECT_MAC_ACCUM_RELU_EN
        if (res[OUT_WIDTH-1]) begin
            res = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: begin
                if (last_tap) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (deliver && !last_tap) begin
                    state_d = StAccum;
                end
            end
        endcase
    end

    always_comb begin
        tap_d  = tap_q;
        acc_d  = acc_q;
        data_d = data_q;
        sat_d  = sat_q;
        if (accept) begin
            if (last_tap) begin
                tap_d  = '0;
                acc_d  = '0;
                data_d = res;
                if (clip_hi || clip_lo) begin
                    sat_d = 1'b1;
                end
            end else begin
                tap_d = tap_q + 1'b1;
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StAccum;
            tap_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign out_data = data_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_myproject_mac_accum.sv
// Self-checking bench for myproject_mac_accum: directed groups with literal results plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_myproject_mac_accum;

    localparam int NT   = 9;
    localparam int FRAC = 10;
    localparam longint OMAX = 32767;
    localparam longint OMIN = -32768;

    logic        ap_clk;
    logic        ap_rst;
    logic [29:0] in_data;
    logic [15:0] in_bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;

    myproject_mac_accum dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_vec = 0;
    int n_bad = 0;
    int stalls = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, floor((sum + half) / 2^FRAC), clamp, optional ReLU.
    function automatic void model_out(input longint s, output longint r, output bit clamped);
        longint t;
        longint div;
        div = longint'(1) << FRAC;
        t = s + (div / 2);
        r = t / div;
        if ((t % div != 0) && (t < 0)) r = r - 1;
        clamped = 1'b0;
        if (r > OMAX) begin
            r = OMAX;
            clamped = 1'b1;
        end else if (r < OMIN) begin
            r = OMIN;
            clamped = 1'b1;
        end
`ifdef MYPROJECT_MAC_ACCUM_RELU_EN
        if (r < 0) r = 0;
`endif
    endfunction

    bit                 m_valid;
    logic signed [15:0] m_data;
    bit                 m_sat;
    int                 g_tap;
    longint             g_sum;

    always @(posedge ap_clk) begin : model
        bit rdy, acc, del, c;
        longint s, r;
        if (ap_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            g_tap   <= 0;
            g_sum   <= 0;
        end else begin
            rdy = !m_valid || out_ready;
            acc = in_valid && rdy;
            del = m_valid && out_ready;
            if (acc) begin
                s = (g_tap == 0) ? longint'($signed(in_bias)) : g_sum;
                s = s + longint'($signed(in_data));
                if (g_tap == NT - 1) begin
                    model_out(s, r, c);
                    m_data  <= 16'(r);
                    m_valid <= 1'b1;
                    g_tap   <= 0;
                    g_sum   <= 0;
                    if (c) m_sat <= 1'b1;
                end else begin
                    g_sum <= s;
                    g_tap <= g_tap + 1;
                    if (del) m_valid <= 1'b0;
                end
            end else if (del) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge ap_clk) begin
        if (checking) begin
            check("out_valid", longint'(out_valid), longint'(m_valid));
            check("in_ready", longint'(in_ready), longint'(!m_valid || out_ready));
            check("out_data", longint'($signed(out_data)), longint'(m_data));
            check("sat_flag", longint'(sat_flag), longint'(m_sat));
        end
    end

    task automatic sync();
        @(posedge ap_clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_beat(input int b, input int d);
        bit r;
        int n;
        in_valid = 1'b1;
        in_bias  = b[15:0];
        in_data  = d[29:0];
        n = 0;
        do begin
            @(negedge ap_clk);
            r = in_ready;
            @(posedge ap_clk);
            #1;
            if (!r) stalls++;
            n++;
        end while (!r && n < 100);
        if (!r) check("accept_timeout", 0, 1);
    endtask

    // Non-zero taps carry random bias that the block must ignore.
    task automatic send_group(input int b, input int first, input int rest);
        int rb;
        send_beat(b, first);
        for (int i = 1; i < NT; i++) begin
            rb = int'($urandom_range(0, 65535));
            send_beat(rb, rest);
        end
    endtask

    task automatic expect_result(input string name, input longint lit);
        in_valid = 1'b0;
        @(negedge ap_clk);
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_data"}, longint'($signed(out_data)), lit);
        check({name, "_model"}, longint'(m_data), lit);
        sync();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bias   = '0;
        out_ready = 1'b1;
        repeat (3) sync();
        checking = 1'b1;
        ap_rst   = 1'b0;

        @(negedge ap_clk);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data", longint'($signed(out_data)), 0);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_ready", longint'(in_ready), 1);
        sync();

        send_group(0, 1024, 1024);
        expect_result("nine_1024", 9);
        @(negedge ap_clk);
        check("one_cycle_valid", longint'(out_valid), 0);
        check("no_sat", longint'(sat_flag), 0);
        sync();

        send_group(512, 1024, 0);
        expect_result("round_pos", 2);
        send_group(-512, -1024, 0);
        expect_result("round_neg", -1);

        send_group(0, 1 << 28, 1 << 28);
        expect_result("sat_hi", 32767);
        send_group(0, -(1 << 28), -(1 << 28));
        expect_result("sat_lo", -32768);

        stalls = 0;
        send_group(0, 2048, 2048);
        send_group(300, -700, 1500);
        send_group(-40, 5000, -333);
        in_valid = 1'b0;
        check("b2b_stalls", longint'(stalls), 0);
        repeat (2) sync();
        @(negedge ap_clk);
        check("sat_sticky", longint'(sat_flag), 1);
        sync();

        out_ready = 1'b0;
        send_group(0, 2048, 2048);
        in_valid = 1'b0;
        @(negedge ap_clk);
        check("hold_valid", longint'(out_valid), 1);
        check("hold_ready", longint'(in_ready), 0);
        check("hold_data", longint'($signed(out_data)), 18);
        sync();
        fork
            send_group(0, 1024, 1024);
            begin
                repeat (6) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        expect_result("after_stall", 9);

        for (int i = 0; i < 5; i++) send_beat(100, 1 << 20);
        in_valid = 1'b0;
        ap_rst = 1'b1;
        sync();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("midrst_valid", longint'(out_valid), 0);
        check("midrst_sat", longint'(sat_flag), 0);
        sync();
        send_group(0, 1024, 1024);
        expect_result("post_rst", 9);

        out_ready = 1'b0;
        send_group(0, 1024, 1024);
        in_valid = 1'b0;
        ap_rst = 1'b1;
        sync();
        ap_rst = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        check("pendrst_valid", longint'(out_valid), 0);
        sync();

        send_group(0, -5120, 0);
`ifdef MYPROJECT_MAC_ACCUM_RELU_EN
        expect_result("relu_neg", 0);
`else
        expect_result("linear_neg", -5);
`endif
        @(negedge ap_clk);
        check("neg_no_sat", longint'(sat_flag), 0);
        sync();

        for (int i = 0; i < 900; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_bias   = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                in_data = 30'($urandom);
            end else begin
                d = int'($urandom_range(0, 16383)) - 8192;
                in_data = d[29:0];
            end
            sync();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) sync();
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/myproject_mac_accum.md
# myproject_mac_accum

Streaming accumulator that sits directly downstream of the 16s×14s→30 signed product multipliers in the pruned CNN datapath. Each accepted beat carries one 30-bit product. The block sums NUM_TAPS products per output neuron, adding a per-neuron bias on the first tap. It then rounds, shifts back to the activation fixed-point format and saturates, and presents one OUT_WIDTH result per group on a valid/ready handshake to the next layer.

## Interface
Parameters:
- PROD_WIDTH, 30: signed product width from the multiplier.
- NUM_TAPS, 9: products per output (3×3 kernel); legal range 1..256.
- ACC_WIDTH, 38: accumulator width; must be ≥ PROD_WIDTH + clog2(NUM_TAPS) + 1.
- BIAS_WIDTH, 16: signed bias width, same fractional alignment as the product.
- FRAC_SHIFT, 10: right shift from product format to output format; ≥ 1.
- OUT_WIDTH, 16: signed output width.

Ports:
- ap_clk  in  1  clock, all state on rising edge.
- ap_rst  in  1  synchronous active-high reset.
- in_data  in  PROD_WIDTH  signed product.
- in_bias  in  BIAS_WIDTH  bias; sampled only on tap 0 of a group.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  OUT_WIDTH  signed result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sat_flag  out  1  sticky flag: at least one result saturated since reset.

## Operation
- Accept occurs when in_valid && in_ready. Results are delivered when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational; there is no other stall source.
- tap_cnt runs 0..NUM_TAPS-1 and advances only on accept.
- Tap 0 accept: acc ← sext(in_bias) + sext(in_data).
- Middle tap accept: acc ← acc + sext(in_data).
- Last tap accept (tap_cnt == NUM_TAPS-1): the block forms sum = acc + sext(in_data), or sext(in_bias) + sext(in_data) when NUM_TAPS = 1.
  - Rounding: r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, arithmetic shift, round-half-up toward +∞.
  - Saturation: r is clamped to [−2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)−1]. If clamping occurs, sat_flag ← 1.
  - Register updates: out_data ← result, out_valid ← 1, tap_cnt ← 0, acc ← 0.
- State machine, two states:
  - ACCUM: out_valid = 0.
  - FULL: out_valid = 1.
  - ACCUM→FULL on last-tap accept.
  - FULL→ACCUM on output handshake with no last-tap accept in the same cycle.
  - FULL stays FULL when a last-tap accept coincides with the output handshake. The new result overwrites out_data and out_valid stays 1.
- While in FULL without out_ready, the partial sum and tap_cnt are held; no beats are lost.
- Accumulator overflow is not detected. Width legality is the integrator's responsibility.

## Timing
- Reset values: out_data = 0, out_valid = 0, sat_flag = 0, tap_cnt = 0, acc = 0. in_ready = 1 in the first cycle after reset.
- Latency: out_valid rises 1 cycle after the last-tap accept.
- Throughput: 1 product/cycle sustained when out_ready stays high. One output per NUM_TAPS cycles, with no bubbles between groups.
- out_data and out_valid are registered. in_ready is combinational from out_valid and out_ready.
- ap_rst asserted mid-group discards the partial sum and any pending output. The next accepted beat after reset is tap 0.
- in_bias on non-zero taps is ignored.

## Configuration
- MYPROJECT_MAC_ACCUM_RELU_EN defined: a negative saturated result is forced to 0 before registering.
  - sat_flag still reflects only clamping.
  - Negative clamping to −2^(OUT_WIDTH-1) is then unreachable at the output.
- Not defined: the signed result passes through unchanged (linear activation).

## Test plan
All scenarios use default parameters, RELU macro off unless noted.
- Nine products of 1024, bias 0, out_ready=1 → out_data=9, out_valid for 1 cycle, 1 cycle after the 9th accept, sat_flag=0.
- Group summing to 1536 (bias 512, products 1024, then eight zeros) → out_data=2. Group summing to −1536 → out_data=−1, verifying round-half-up.
- Nine products of 2^28 → out_data=32767, sat_flag=1 and remaining 1 after later in-range groups. Nine products of −2^28 → −32768.
- Back-to-back 27 beats with out_ready=1 → three results on consecutive 9-cycle boundaries, in_ready constantly 1. Then out_ready=0 with a fourth group → in_ready=0 after that result registers; beats are held with no loss, and the result is correct once out_ready returns.
- Assert ap_rst after tap 4 of a group → out_valid=0, then a fresh 9-tap group of 1024 with bias 0 yields 9, not polluted by the discarded partial sum.
- With MYPROJECT_MAC_ACCUM_RELU_EN defined, a group summing to −5120 → out_data=0, sat_flag unchanged. Without the macro → out_data=−5.
